conway_run_ctrl: RTL and testbench
==================================

# conway_run_ctrl

Run controller for the 16x16 toroidal Conway life core: loads a seed, lets the core advance one generation per clock, and freezes it on a terminating condition. Terminating conditions are extinction, still life, period-2 oscillation, generation limit or abort. It sits between a host request interface (start/seed/limit) and the core's `load`/`data`/`q` ports, and reports the final generation count and the reason for stopping.

## Interface
- `GEN_W`, 16, width of generation counter and limit
- `clk`  in  1  rising-edge clock, shared with the life core
- `reset`  in  1  synchronous, active-high
- `start`  in  1  run request; sampled only in IDLE
- `seed`  in  256  initial board; cell (row r, col c) = bit 16r+c; sampled with `start`
- `max_gens`  in  GEN_W  generation limit; sampled with `start`
- `abort`  in  1  stop request; honoured only in RUN
- `life_q`  in  256  core state `q`
- `life_load`  out  1  to core `load`
- `life_data`  out  256  to core `data`
- `busy`  out  1  high in LOAD and RUN
- `done`  out  1  one-cycle pulse in DONE
- `gens`  out  GEN_W  generation index of the frozen board
- `status`  out  3  0 none/limit, 1 extinct, 2 still, 3 period-2, 4 aborted

## Operation
- The core advances whenever `life_load`=0. Hold is done by reloading the current state: `life_load`=1 and `life_data`=`life_q`.
- IDLE:
  - hold core; `busy`=0
  - on `start`: register `seed`→seed_r and `max_gens`→lim_r, then go to LOAD
- LOAD (1 cycle):
  - `life_load`=1, `life_data`=seed_r
  - gens←0; next state RUN
- RUN: each cycle `life_q` is generation `gens`. Evaluate the terminate conditions in this priority order:
  1. `abort` → status 4
  2. `life_q`==0 → status 1
  3. gens≥1 and `life_q`==prev1 → status 2
  4. gens≥2 and `life_q`==prev2 → status 3
  5. gens==lim_r → status 0
- On terminate, in the same cycle (combinationally): `life_load`=1, `life_data`=`life_q`. This freezes the core at generation `gens`. Latch status; `gens` holds; go to DONE.
- Otherwise:
  - `life_load`=0
  - prev2←prev1, prev1←`life_q`, gens←gens+1
- DONE (1 cycle): hold core; `done`=1; go to IDLE.
- `gens` and `status` hold their values through IDLE until the next LOAD.
- `start` outside IDLE is ignored; `abort` outside RUN is ignored.
- `gens` never wraps: lim_r ≤ 2^GEN_W−1 guarantees a limit stop first.
- The comparisons are full 256-bit equality on `life_q`; prev1/prev2 are internal 256-bit registers.

## Timing
- Reset:
  - state←IDLE, `busy`=0, `done`=0, `gens`=0, `status`=0; prev1/prev2 cleared
  - while `reset`=1, `life_load`=1 and `life_data`=`life_q`, regardless of state
  - reset mid-run therefore freezes the core at the state present in the reset cycle
- `start` in cycle t:
  - LOAD in t+1, with `busy`=1
  - `life_q`=seed and RUN with gens=0 in t+2
  - generation k visible in cycle t+2+k
- Termination detected in cycle c: `done`=1 and `busy`=0 in c+1; IDLE in c+2. A new `start` is accepted from c+2.
- `max_gens`=0: stops at gens 0 with the seed intact (status 0 unless the seed is empty → status 1).
- Run latency for a limit stop = lim_r+3 cycles, from `start` to `done`.

## Test plan
- Seed = 0, `max_gens`=5, `start` → RUN detects extinction immediately; `done` 3 cycles after start, gens=0, status=1, `life_q`=0.
- Block (bits 17,18,33,34), `max_gens`=100 → gens=1, status=2, `life_q` stays = block for 10 idle cycles.
- Horizontal blinker (bits 84,85,86), `max_gens`=100 → gens=2, status=3, `life_q`=seed after `done`.
- Glider (bits 1,18,32,33,34), `max_gens`=10 → gens=10, status=0, `done` at start+13, `life_q` equals software-model generation 10, frozen afterwards.
- Glider, `max_gens`=1000, `abort` 5 cycles after start → gens=3, status=4, core frozen at generation 3; `start` pulsed during RUN has no effect.
- Glider run, `reset` asserted at RUN gens=4 → `busy`=0, `gens`=0, `status`=0 next cycle; `life_q` held at generation 4; a following `start` with a block seed completes normally (gens=1, status=2).

Source files
------------

// File: rtl/conway_run_ctrl.sv
// conway_run_ctrl
// Run controller for a 16x16 toroidal Conway life core. Loads a host seed into
// the core, lets it advance one generation per clock, and freezes it when the
// board dies out, becomes a still life, becomes a period-2 oscillator, reaches
// the generation limit, or the host aborts.
//
// Ports:
//   i_clk        rising-edge clock, shared with the life core
//   i_reset      synchronous active-high reset
//   i_start      run request, accepted only in IDLE
//   i_seed       initial board, cell (r,c) = bit 16r+c, sampled with i_start
//   i_max_gens   generation limit, sampled with i_start
//   i_abort      stop request, honoured only in RUN
//   i_life_q     current core board
//   o_life_load  core load strobe (core advances when low)
//   o_life_data  core load data
//   o_busy       high in LOAD and RUN
//   o_done       one-cycle pulse after a run stops
//   o_gens       generation index of the frozen board
//   o_status     0 limit, 1 extinct, 2 still, 3 period-2, 4 aborted
module conway_run_ctrl #(
  parameter int unsigned GEN_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [255:0]     i_seed,
  input  logic [GEN_W-1:0] i_max_gens,
  input  logic             i_abort,
  input  logic [255:0]     i_life_q,
  output logic             o_life_load,
  output logic [255:0]     o_life_data,
  output logic             o_busy,
  output logic             o_done,
  output logic [GEN_W-1:0] o_gens,
  output logic [2:0]       o_status
);

  localparam logic [2:0] StatusLimit   = 3'd0;
  localparam logic [2:0] StatusExtinct = 3'd1;
  localparam logic [2:0] StatusStill   = 3'd2;
  localparam logic [2:0] StatusPeriod2 = 3'd3;
  localparam logic [2:0] StatusAbort   = 3'd4;

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [255:0]     r_seed;
  logic [GEN_W-1:0] r_lim;
  logic [GEN_W-1:0] r_gens;
  logic [2:0]       r_status;
  logic [255:0]     r_prev1;
  logic [255:0]     r_prev2;

  logic             w_term;
  logic [2:0]       w_term_status;

  // Terminate conditions in priority order; only meaningful in RUN.
  always_comb begin
    w_term        = 1'b1;
    w_term_status = StatusLimit;
    if (i_abort) begin
      w_term_status = StatusAbort;
    end else if (i_life_q == '0) begin
      w_term_status = StatusExtinct;
    end else if ((r_gens >= GEN_W'(1)) && (i_life_q == r_prev1)) begin
      w_term_status = StatusStill;
    end else if ((r_gens >= GEN_W'(2)) && (i_life_q == r_prev2)) begin
      w_term_status = StatusPeriod2;
    end else if (r_gens == r_lim) begin
      w_term_status = StatusLimit;
    end else begin
      w_term = 1'b0;
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (i_start) w_state_next = StLoad;
      StLoad: w_state_next = StRun;
      StRun:  if (w_term) w_state_next = StDone;
      StDone: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs. Holding the core means reloading its own state; reset forces a
  // hold so a reset mid-run freezes the board present in the reset cycle.
  always_comb begin
    o_life_load = 1'b1;
    o_life_data = i_life_q;
    if (!i_reset) begin
      unique case (r_state)
        StLoad:  o_life_data = r_seed;
        StRun:   o_life_load = w_term;
        default: ;
      endcase
    end
  end

  assign o_busy   = (r_state == StLoad) || (r_state == StRun);
  assign o_done   = (r_state == StDone);
  assign o_gens   = r_gens;
  assign o_status = r_status;

  // Run datapath: request capture, generation count and history registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_seed   <= '0;
      r_lim    <= '0;
      r_gens   <= '0;
      r_status <= StatusLimit;
      r_prev1  <= '0;
      r_prev2  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_seed <= i_seed;
            r_lim  <= i_max_gens;
          end
        end
        StLoad: begin
          r_gens   <= '0;
          r_status <= StatusLimit;
          r_prev1  <= '0;
          r_prev2  <= '0;
        end
        StRun: begin
          if (w_term) begin
            r_status <= w_term_status;
          end else begin
            r_prev2 <= r_prev1;
            r_prev1 <= i_life_q;
            r_gens  <= r_gens + GEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conway_run_ctrl.sv
module tb_conway_run_ctrl;
  localparam int unsigned GenW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [255:0]    seed;
  logic [GenW-1:0] max_gens;
  logic            abort;
  logic            life_load;
  logic [255:0]    life_data;
  logic [255:0]    core_q = '0;
  logic            busy;
  logic            done;
  logic [GenW-1:0] gens;
  logic [2:0]      status;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  conway_run_ctrl #(.GEN_W(GenW)) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_start    (start),
    .i_seed     (seed),
    .i_max_gens (max_gens),
    .i_abort    (abort),
    .i_life_q   (core_q),
    .o_life_load(life_load),
    .o_life_data(life_data),
    .o_busy     (busy),
    .o_done     (done),
    .o_gens     (gens),
    .o_status   (status)
  );

  // Toroidal life step on a 16x16 board.
  function automatic logic [255:0] life_step(input logic [255:0] b);
    logic [255:0] n;
    int cnt;
    n = '0;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              cnt += int'(b[((r + dr + 16) % 16) * 16 + ((c + dc + 16) % 16)]);
            end
          end
        end
        n[r * 16 + c] = (cnt == 3) || (b[r * 16 + c] && cnt == 2);
      end
    end
    return n;
  endfunction

  // Behavioural life core.
  always @(posedge clk) core_q <= life_load ? life_data : life_step(core_q);

  // Generation-level prediction of a run. abort_delay is the cycle after start
  // in which abort is pulsed (-1 for none); RUN with gens=k is start+2+k.
  function automatic void predict(input logic [255:0] s, input int lim, input int abort_delay,
                                  output int g, output int st, output logic [255:0] b);
    logic [255:0] p1, p2;
    int ag;
    ag = (abort_delay >= 2) ? abort_delay - 2 : -1;
    b  = s;
    g  = 0;
    p1 = '0;
    p2 = '0;
    st = -1;
    while (st < 0) begin
      if (g == ag) st = 4;
      else if (b == '0) st = 1;
      else if (g >= 1 && b == p1) st = 2;
      else if (g >= 2 && b == p2) st = 3;
      else if (g == lim) st = 0;
      else begin
        p2 = p1;
        p1 = b;
        b  = life_step(b);
        g++;
      end
    end
  endfunction

  function automatic logic [255:0] rand_board();
    logic [255:0] b;
    for (int i = 0; i < 8; i++) b[i * 32 +: 32] = $urandom & $urandom;
    return b;
  endfunction

  function automatic logic [255:0] set_bits(input int a, input int b2, input int c, input int d,
                                            input int e);
    logic [255:0] x;
    x = '0;
    if (a >= 0) x[a] = 1'b1;
    if (b2 >= 0) x[b2] = 1'b1;
    if (c >= 0) x[c] = 1'b1;
    if (d >= 0) x[d] = 1'b1;
    if (e >= 0) x[e] = 1'b1;
    return x;
  endfunction

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete run; exp_gens/exp_status < 0 means "model only".
  task automatic run_case(input string name, input logic [255:0] s, input int lim,
                          input int abort_delay, input int noise_delay,
                          input int exp_gens, input int exp_status);
    int pg, ps, done_cyc, budget;
    logic [255:0] pb;
    predict(s, lim, abort_delay, pg, ps, pb);
    done_cyc = -1;
    budget   = pg + 10;
    for (int cyc = 0; cyc < budget && done_cyc < 0; cyc++) begin
      start    = (cyc == 0) || (cyc == noise_delay);
      abort    = (cyc == abort_delay);
      seed     = (cyc == 0) ? s : rand_board();
      max_gens = (cyc == 0) ? GenW'(lim) : GenW'($urandom);
      #1;
      if (cyc == 1) begin
        check_val({name, " load busy"}, busy, 1'b1);
        check_val({name, " load strobe"}, life_load, 1'b1);
        check_val({name, " load data"}, life_data, s);
      end
      if (done) begin
        done_cyc = cyc;
        check_val({name, " gens"}, gens, pg);
        check_val({name, " status"}, status, ps);
        check_val({name, " busy at done"}, busy, 1'b0);
        check_val({name, " board at done"}, core_q, pb);
        if (exp_gens >= 0) check_val({name, " gens const"}, gens, exp_gens);
        if (exp_status >= 0) check_val({name, " status const"}, status, exp_status);
      end
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    check_val({name, " done latency"}, done_cyc, pg + 3);
    repeat (10) tick();
    check_val({name, " frozen board"}, core_q, pb);
    check_val({name, " gens held"}, gens, pg);
    check_val({name, " status held"}, status, ps);
    check_val({name, " idle busy"}, busy, 1'b0);
    check_val({name, " idle done"}, done, 1'b0);
  endtask

  initial begin
    logic [255:0] glider, block, blinker, b4, rb;
    int lim, ad, nd, pg, ps;
    logic [255:0] pb;

    glider  = set_bits(1, 18, 32, 33, 34);
    block   = set_bits(17, 18, 33, 34, -1);
    blinker = set_bits(84, 85, 86, -1, -1);

    reset    = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    seed     = '0;
    max_gens = '0;
    repeat (3) tick();
    check_val("reset busy", busy, 1'b0);
    check_val("reset done", done, 1'b0);
    check_val("reset gens", gens, 0);
    check_val("reset status", status, 0);
    check_val("reset load", life_load, 1'b1);
    reset = 1'b0;
    tick();

    run_case("empty", '0, 5, -1, -1, 0, 1);
    run_case("block", block, 100, -1, -1, 1, 2);
    run_case("blinker", blinker, 100, -1, -1, 2, 3);
    run_case("glider lim", glider, 10, -1, -1, 10, 0);
    run_case("glider abort", glider, 1000, 5, 4, 3, 4);
    run_case("lim zero", glider, 0, -1, -1, 0, 0);

    // Reset in RUN at gens=4 freezes the core at generation 4.
    b4 = glider;
    repeat (4) b4 = life_step(b4);
    for (int cyc = 0; cyc < 6; cyc++) begin
      start    = (cyc == 0);
      seed     = glider;
      max_gens = GenW'(1000);
      tick();
    end
    start = 1'b0;
    reset = 1'b1;
    #1;
    check_val("mid reset gens", gens, 4);
    check_val("mid reset load", life_load, 1'b1);
    tick();
    reset = 1'b0;
    check_val("post reset busy", busy, 1'b0);
    check_val("post reset gens", gens, 0);
    check_val("post reset status", status, 0);
    check_val("post reset board", core_q, b4);
    repeat (5) tick();
    check_val("post reset held", core_q, b4);
    run_case("block after reset", block, 100, -1, -1, 1, 2);

    for (int i = 0; i < 8; i++) begin
      rb  = rand_board();
      lim = $urandom_range(0, 30);
      ad  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 30) : -1;
      predict(rb, lim, ad, pg, ps, pb);
      nd  = 2 + $urandom_range(0, pg + 1);
      run_case($sformatf("rand%0d", i), rb, lim, ad, nd, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
